// File: rtl/mem_bus_bridge.sv
// CPU memory strobes to req/ack bus; ack in first BUSY cycle gives oRdy 2 cycles after the strobe.
// The CPU stalls (oRdy low) while the bus waits, bounded by TIMEOUT; a timeout returns ERR_DATA and pulses oErr.
module mem_bus_bridge #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic              iRead,
  input  logic              iWrite,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [DATA_W-1:0] iWData,
  output logic [DATA_W-1:0] oRData,
  output logic              oRdy,
  output logic              oErr,
  output logic              oBusReq,
  output logic              oBusWE,
  output logic [ADDR_W-1:0] oBusAddr,
  output logic [DATA_W-1:0] oBusWData,
  input  logic              iBusAck,
  input  logic [DATA_W-1:0] iBusRData
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt;
  logic       strobe;
  logic       start;
  logic       ack_hit;
  logic       timeout_hit;

  assign strobe = iRead | iWrite;

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    oRdy        = 1'b0;
    start       = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        oRdy = !strobe;
        if (strobe) begin
          start   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (iBusAck) begin
          ack_hit = 1'b1;
          state_d = DONE;
        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        oRdy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      oRData    <= '0;
      oErr      <= 1'b0;
      oBusReq   <= 1'b0;
      oBusWE    <= 1'b0;
      oBusAddr  <= '0;
      oBusWData <= '0;
      wait_cnt  <= '0;
    end else begin
      oErr <= timeout_hit;
      if (start) begin
        oBusAddr  <= iAddr;
        oBusWData <= iWData;
        oBusWE    <= iWrite;
        oBusReq   <= 1'b1;
        wait_cnt  <= '0;
      end
      if (state_q == BUSY && wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
      // Bus regs stay as they were after completion; only the request drops.
      if (ack_hit || timeout_hit) begin
        oBusReq <= 1'b0;
        if (!oBusWE)
          oRData <= ack_hit ? iBusRData : ERR_DATA;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed and randomized transaction sequence checked against a transaction-level model.
module tb_mem_bus_bridge;
  localparam int TO = 15;

  logic        iClk = 1'b0;
  logic        nRst;
  logic        iRead, iWrite, iBusAck;
  logic [31:0] iAddr, iWData, iBusRData;
  logic [31:0] oRData, oBusAddr, oBusWData;
  logic        oRdy, oErr, oBusReq, oBusWE;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_rdata;

  mem_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .ERR_DATA(32'hFFFF_FFFF)) dut (
    .iClk(iClk), .nRst(nRst), .iRead(iRead), .iWrite(iWrite), .iAddr(iAddr),
    .iWData(iWData), .oRData(oRData), .oRdy(oRdy), .oErr(oErr), .oBusReq(oBusReq),
    .oBusWE(oBusWE), .oBusAddr(oBusAddr), .oBusWData(oBusWData), .iBusAck(iBusAck),
    .iBusRData(iBusRData)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One complete transaction: strobe applied in an IDLE cycle, ack after 'waits'
  // wait cycles (waits >= TO means the bus never answers). Returns in the DONE cycle.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] rdat, input int waits);
    bit timed_out = (waits >= TO);
    int req_cycles = timed_out ? TO : waits + 1;
    @(posedge iClk); #1;
    iRead = rd; iWrite = wr; iAddr = a; iWData = d; iBusAck = 1'b0;
    #1;
    chk("idle_rdy_low", 32'(oRdy), 32'd0);
    for (int k = 1; k <= req_cycles; k++) begin
      @(posedge iClk); #1;
      iAddr = $urandom; iWData = $urandom;
      iBusAck   = (!timed_out && k == waits + 1);
      iBusRData = iBusAck ? rdat : $urandom;
      #1;
      chk("busy_req", 32'(oBusReq), 32'd1);
      chk("busy_we", 32'(oBusWE), 32'(wr));
      chk("busy_addr", oBusAddr, a);
      chk("busy_wdata", oBusWData, d);
      chk("busy_rdy", 32'(oRdy), 32'd0);
      chk("busy_err", 32'(oErr), 32'd0);
    end
    if (rd && !wr) exp_rdata = timed_out ? 32'hFFFF_FFFF : rdat;
    @(posedge iClk); #1;
    iBusAck = 1'($urandom); iBusRData = $urandom;
    #1;
    chk("done_rdy", 32'(oRdy), 32'd1);
    chk("done_err", 32'(oErr), 32'(timed_out));
    chk("done_req", 32'(oBusReq), 32'd0);
    chk("done_rdata", oRData, exp_rdata);
    chk("done_addr_held", oBusAddr, a);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge iClk); #1;
      iRead = 1'b0; iWrite = 1'b0; iBusAck = 1'b1; iBusRData = $urandom;
      #1;
      chk("idle_rdy", 32'(oRdy), 32'd1);
      chk("idle_req", 32'(oBusReq), 32'd0);
      chk("idle_err", 32'(oErr), 32'd0);
      chk("idle_rdata", oRData, exp_rdata);
    end
  endtask

  initial begin
    nRst = 1'b0; iRead = 1'b0; iWrite = 1'b0; iBusAck = 1'b0;
    iAddr = '0; iWData = '0; iBusRData = '0;
    exp_rdata = '0;
    #12;
    chk("rst_rdata", oRData, 32'd0);
    chk("rst_req", 32'(oBusReq), 32'd0);
    chk("rst_we", 32'(oBusWE), 32'd0);
    chk("rst_addr", oBusAddr, 32'd0);
    chk("rst_wdata", oBusWData, 32'd0);
    chk("rst_err", 32'(oErr), 32'd0);
    chk("rst_rdy", 32'(oRdy), 32'd1);
    @(negedge iClk); nRst = 1'b1;

    txn(1'b1, 1'b0, 32'h10, 32'h0, 32'hCAFE_0001, 0);
    idle(1);
    txn(1'b0, 1'b1, 32'h20, 32'h1234_5678, 32'hDEAD_BEEF, 3);
    idle(1);
    txn(1'b1, 1'b0, 32'h30, 32'h0, 32'h0, TO + 5);
    idle(1);
    txn(1'b1, 1'b0, 32'h40, 32'h0, 32'h5555_AAAA, TO - 1);
    idle(1);
    // Strobe held through DONE: two separate transactions.
    txn(1'b1, 1'b0, 32'h50, 32'h0, 32'h1111_2222, 0);
    txn(1'b1, 1'b0, 32'h54, 32'h0, 32'h3333_4444, 1);
    idle(1);
    txn(1'b1, 1'b1, 32'h60, 32'hABCD_0000, 32'h7777_7777, 2);
    idle(3);

    // Reset in the second BUSY cycle.
    @(posedge iClk); #1;
    iRead = 1'b1; iAddr = 32'h70; iBusAck = 1'b0;
    @(posedge iClk); #1;
    @(posedge iClk); #1;
    nRst = 1'b0;
    #1;
    exp_rdata = '0;
    chk("mid_rst_req", 32'(oBusReq), 32'd0);
    chk("mid_rst_addr", oBusAddr, 32'd0);
    chk("mid_rst_rdata", oRData, 32'd0);
    chk("mid_rst_err", 32'(oErr), 32'd0);
    chk("mid_rst_rdy", 32'(oRdy), 32'd0);
    iRead = 1'b0; iBusAck = 1'b1; iBusRData = 32'h9999_9999;
    repeat (2) @(posedge iClk);
    #1; nRst = 1'b1; iBusAck = 1'b0;
    #1;
    chk("post_rst_rdata", oRData, 32'd0);
    chk("post_rst_rdy", 32'(oRdy), 32'd1);
    txn(1'b1, 1'b0, 32'h80, 32'h0, 32'h0BAD_F00D, 1);
    idle(1);

    for (int i = 0; i < 25; i++) begin
      logic rd, wr;
      rd = 1'($urandom); wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      txn(rd, wr, $urandom, $urandom, $urandom, int'($urandom_range(0, TO + 2)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
